// File: rtl/st2bus_pkg.sv
// st2bus_pkg: header field layout and FSM state type shared by the st2bus packer.
// hdr_t is the header layout for the default widths (PKT_ID_W=8, 22-bit header).
package st2bus_pkg;
    localparam int IDX_W = 8;
    localparam int IDX_O = 0;
    localparam int PID_O = IDX_O + IDX_W;
    typedef enum logic {IDLE, PKT} state_t;
    typedef struct packed {
        logic [3:0] rsvd;
        logic       err;
        logic       last;
        logic [7:0] pkt_id;
        logic [7:0] word_idx;
    } hdr_t;
endpackage

// File: rtl/st2bus_fifo.sv
// st2bus_fifo: synchronous word FIFO with a registered occupancy count.
module st2bus_fifo #(
    parameter int W     = 534,
    parameter int DEPTH = 8
) (
    input  logic                   clk_bus,
    input  logic                   rst,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          we, re;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign we    = wr && !full;
    assign re    = rd && !empty;
    assign rdata = mem[rp];
    always_ff @(posedge clk_bus)
        if (we) mem[wp] <= wdata;
    always_ff @(posedge clk_bus or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (we) wp <= wp + AW'(1);
            if (re) rp <= rp + AW'(1);
            count <= count + (AW+1)'(we) - (AW+1)'(re);
        end
endmodule

// File: rtl/st2bus_pack.sv
// st2bus_pack: packs Avalon-ST beats into {hdr, payload} bus words, buffers them in a
// word FIFO and emits one registered word per cycle while the bus is ready.
module st2bus_pack
    import st2bus_pkg::*;
#(
    parameter int BUS        = 534,
    parameter int ST_PER_BUS = 512,
    parameter int ST         = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PKT_ID_W   = 8
) (
    input  logic           clk_bus,
    input  logic           rst,
    input  logic [ST-1:0]  st_data,
    input  logic           st_valid,
    input  logic           st_sop,
    input  logic           st_eop,
    output logic           st_ready,
    input  logic           bus_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_en,
    output logic           data2FlowCtrl,
    output logic           proto_err
);
    localparam int HDR_W  = BUS - ST_PER_BUS;
    localparam int NB     = ST_PER_BUS / ST;
    localparam int KW     = NB > 1 ? $clog2(NB) : 1;
    localparam int LAST_O = PID_O + PKT_ID_W;
    localparam int ERR_O  = LAST_O + 1;
    if (HDR_W < 18 || HDR_W < ERR_O + 1 || ST_PER_BUS % ST != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("st2bus_pack: illegal parameter combination");
    end
    state_t                state, state_n;
    logic [KW-1:0]         k, k_n, pos;
    logic [ST_PER_BUS-1:0] pay, pay_n, nw;
    logic [IDX_W-1:0]      widx, widx_n, wbase;
    logic [PKT_ID_W-1:0]   pid, pid_n, pid_cur;
    logic [HDR_W-1:0]      hdr;
    logic [BUS-1:0]        wdata, rdata;
    logic                  rdy_en, acc, restart, drop, good, err_close, close_new, wr, perr;
    logic                  full, empty, pop;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_unused;
    assign st_ready = rdy_en && !full;
    assign pop      = bus_ready && !empty;
    // A sop beat (or any beat in IDLE) starts a fresh word at slot 0; otherwise it fills slot k.
    always_comb begin
        acc       = st_valid && st_ready;
        restart   = state == IDLE || st_sop;
        pos       = restart ? '0 : k;
        wbase     = restart ? '0 : widx;
        nw        = restart ? '0 : pay;
        nw[pos*ST +: ST] = st_data;
        drop      = state == IDLE ? !st_sop : st_sop && st_eop;
        err_close = acc && state == PKT && st_sop && k != '0;
        good      = acc && !drop;
        close_new = good && (st_eop || int'(pos) == NB - 1);
        wr        = err_close || close_new;
        perr      = acc && (state == IDLE ? !st_sop : st_sop);
        pid_cur   = acc && state == PKT && st_sop ? pid + PKT_ID_W'(1) : pid;
        pid_n     = close_new && st_eop ? pid_cur + PKT_ID_W'(1) : pid_cur;
        hdr       = '0;
        hdr[IDX_O +: IDX_W]    = err_close ? widx : wbase;
        hdr[PID_O +: PKT_ID_W] = err_close ? pid : pid_cur;
        hdr[LAST_O] = err_close || st_eop;
        hdr[ERR_O]  = err_close;
        wdata   = {hdr, err_close ? pay : nw};
        state_n = acc ? (drop || st_eop ? IDLE : PKT) : state;
        k_n     = good ? (close_new ? '0 : pos + KW'(1)) : acc && drop ? '0 : k;
        pay_n   = good ? (close_new ? '0 : nw) : acc && drop ? '0 : pay;
        widx_n  = good ? (close_new ? (st_eop ? '0 : wbase + IDX_W'(1)) : wbase) :
                  acc && drop ? '0 : widx;
    end
    always_ff @(posedge clk_bus or posedge rst)
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            pay           <= '0;
            widx          <= '0;
            pid           <= '0;
            rdy_en        <= 1'b0;
            proto_err     <= 1'b0;
            bus_en        <= 1'b0;
            bus_data      <= '0;
            data2FlowCtrl <= 1'b0;
        end else begin
            state         <= state_n;
            k             <= k_n;
            pay           <= pay_n;
            widx          <= widx_n;
            pid           <= pid_n;
            rdy_en        <= 1'b1;
            proto_err     <= perr;
            bus_en        <= pop;
            data2FlowCtrl <= pop && rdata[ST_PER_BUS + LAST_O];
            if (pop) bus_data <= rdata;
        end
    st2bus_fifo #(.W(BUS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_bus(clk_bus),
        .rst(rst),
        .wr(wr),
        .rd(pop),
        .wdata(wdata),
        .rdata(rdata),
        .full(full),
        .empty(empty),
        .count(fifo_cnt_unused)
    );
endmodule

// File: tb/tb_st2bus_pack.sv
// tb_st2bus_pack: directed packets checked every cycle against a packet-level byte-queue
// model, plus literal expectations on selected words, latency, stalls and error pulses.
`timescale 1ns/1ps
module tb_st2bus_pack;
    import st2bus_pkg::*;
    localparam int BUS = 534, SPB = 512, ST = 8, DEPTH = 4, NB = SPB / ST;
    logic           clk_bus = 0, rst = 1;
    logic [ST-1:0]  st_data = '0;
    logic           st_valid = 0, st_sop = 0, st_eop = 0, bus_ready = 1;
    logic           st_ready, bus_en, data2FlowCtrl, proto_err;
    logic [BUS-1:0] bus_data;

    st2bus_pack #(.BUS(BUS), .ST_PER_BUS(SPB), .ST(ST), .FIFO_DEPTH(DEPTH), .PKT_ID_W(8)) dut (
        .clk_bus(clk_bus),
        .rst(rst),
        .st_data(st_data),
        .st_valid(st_valid),
        .st_sop(st_sop),
        .st_eop(st_eop),
        .st_ready(st_ready),
        .bus_ready(bus_ready),
        .bus_data(bus_data),
        .bus_en(bus_en),
        .data2FlowCtrl(data2FlowCtrl),
        .proto_err(proto_err)
    );

    always #5 clk_bus = ~clk_bus;

    int             ncmp = 0, nfail = 0, cyc = 0, nemit = 0, perr_seen = 0, exp_perr = 0, last_acc = 0;
    logic [BUS-1:0] expq[$];
    logic [BUS-1:0] got [64];
    int             ecyc [64];
    logic [7:0]     cur[$];
    logic [7:0]     m_pid = 0, m_widx = 0;
    bit             m_in = 0;

    always @(posedge clk_bus) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic hdr_t hdr(input logic [BUS-1:0] w);
        return hdr_t'(w[BUS-1:SPB]);
    endfunction

    function automatic logic [BUS-1:0] mkword(input logic last, input logic err);
        logic [SPB-1:0] p = '0;
        foreach (cur[i]) p[i*8 +: 8] = cur[i];
        return {4'b0, err, last, m_pid, m_widx, p};
    endfunction

    // Reference: bytes of the open word sit in cur; a word closes on eop, when full, or on a stray sop.
    task automatic model_accept(input logic [7:0] d, input logic s, input logic e);
        if (!m_in && !s) begin
            exp_perr++;
            return;
        end
        if (m_in && s) begin
            exp_perr++;
            if (cur.size() > 0) expq.push_back(mkword(1'b1, 1'b1));
            m_pid++;
            cur.delete();
            m_widx = 0;
            m_in = 0;
            if (e) return;
        end
        m_in = 1;
        cur.push_back(d);
        if (e || cur.size() == NB) begin
            expq.push_back(mkword(e, 1'b0));
            cur.delete();
            if (e) begin
                m_pid++;
                m_widx = 0;
                m_in = 0;
            end else m_widx++;
        end
    endtask

    task automatic model_reset();
        expq.delete();
        cur.delete();
        m_pid = 0;
        m_widx = 0;
        m_in = 0;
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        st_data = d;
        st_sop = s;
        st_eop = e;
        st_valid = 1;
        while (!st_ready && n < 200) begin
            @(negedge clk_bus);
            n++;
        end
        if (!st_ready) check("beat_timeout", st_ready, 1);
        else begin
            model_accept(d, s, e);
            last_acc = cyc;
            @(negedge clk_bus);
        end
        st_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || n < 3) && n < 300) begin
            @(negedge clk_bus);
            n++;
        end
        check("drain_left", expq.size(), 0);
    endtask

    always @(negedge clk_bus) begin
        logic [BUS-1:0] w;
        if (!rst) begin
            if (bus_en) begin
                if (expq.size() == 0) check("unexpected_word", bus_en, 0);
                else begin
                    w = expq.pop_front();
                    check("bus_data", bus_data, w);
                    check("flow_last", data2FlowCtrl, w[SPB+16]);
                end
                if (nemit < 64) begin
                    got[nemit] = bus_data;
                    ecyc[nemit] = cyc;
                end
                nemit++;
            end else check("flow_idle", data2FlowCtrl, 0);
            if (proto_err) perr_seen++;
        end
    end

    initial begin
        int b, c, p0;
        repeat (2) @(negedge clk_bus);
        check("rst_bus_en", bus_en, 0);
        check("rst_st_ready", st_ready, 0);
        check("rst_flow", data2FlowCtrl, 0);
        check("rst_perr", proto_err, 0);
        check("rst_bus_data", bus_data, 0);
        rst = 0;
        @(negedge clk_bus);

        b = nemit;
        c = 0;
        for (int i = 0; i < 128; i++) begin
            beat(8'(i), i == 0, i == 127);
            if (i == 63) c = last_acc;
        end
        drain();
        check("t1_words", nemit - b, 2);
        check("t1_w0_byte0", got[b][7:0], 8'h00);
        check("t1_w0_byte63", got[b][511:504], 8'h3F);
        check("t1_w0_hdr", got[b][BUS-1:SPB], 22'h00000);
        check("t1_w1_hdr", got[b+1][BUS-1:SPB], 22'h10001);
        check("t1_latency", ecyc[b] - c, 2);

        b = nemit;
        for (int i = 0; i < 70; i++) beat(8'(i), i == 0, i == 69);
        drain();
        check("t2_words", nemit - b, 2);
        check("t2_w0_pid", hdr(got[b]).pkt_id, 1);
        check("t2_w1_tail", got[b+1][47:0], 48'h454443424140);
        check("t2_w1_pad", got[b+1][511:48], 0);
        check("t2_w1_last", hdr(got[b+1]).last, 1);
        check("t2_w1_idx", hdr(got[b+1]).word_idx, 1);

        bus_ready = 0;
        b = nemit;
        for (int i = 0; i < 256; i++) beat(8'(i), i == 0, 1'b0);
        check("t3_stall", st_ready, 0);
        repeat (3) @(negedge clk_bus);
        check("t3_still_stalled", st_ready, 0);
        check("t3_held", nemit - b, 0);
        bus_ready = 1;
        c = cyc;
        for (int i = 256; i < 384; i++) beat(8'(i), 1'b0, i == 383);
        drain();
        check("t3_words", nemit - b, 6);
        check("t3_first_out", ecyc[b] - c, 1);
        check("t3_back_to_back", ecyc[b+3] - ecyc[b], 3);
        check("t3_w4_byte0", got[b+4][7:0], 8'h00);
        check("t3_w5_hdr", got[b+5][BUS-1:SPB], 22'h10205);

        b = nemit;
        p0 = perr_seen;
        for (int i = 0; i < 30; i++) beat(8'(i), i == 0, 1'b0);
        for (int i = 0; i < 10; i++) beat(8'(8'hA0 + i), i == 0, i == 9);
        drain();
        check("t4_words", nemit - b, 2);
        check("t4_err_hdr", got[b][BUS-1:SPB], 22'h30300);
        check("t4_err_payload", got[b][239:0],
              240'h1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
        check("t4_err_pad", got[b][511:240], 0);
        check("t4_new_hdr", got[b+1][BUS-1:SPB], 22'h10400);
        check("t4_new_payload", got[b+1][79:0], 80'hA9A8A7A6A5A4A3A2A1A0);
        check("t4_perr", perr_seen - p0, 1);

        b = nemit;
        p0 = perr_seen;
        for (int i = 0; i < 5; i++) beat(8'(8'h50 + i), 1'b0, 1'b0);
        repeat (3) @(negedge clk_bus);
        check("t5_perr", perr_seen - p0, 5);
        check("t5_no_words", nemit - b, 0);
        for (int i = 0; i < 3; i++) beat(8'(8'hC0 + i), i == 0, i == 2);
        drain();
        check("t5_hdr", got[b][BUS-1:SPB], 22'h10500);
        check("t5_payload", got[b][23:0], 24'hC2C1C0);
        check("t5_pad", got[b][511:24], 0);

        b = nemit;
        for (int i = 0; i < 40; i++) beat(8'(i), i == 0, 1'b0);
        rst = 1;
        model_reset();
        #1;
        check("t6_bus_en", bus_en, 0);
        check("t6_st_ready", st_ready, 0);
        check("t6_flow", data2FlowCtrl, 0);
        @(negedge clk_bus);
        rst = 0;
        #1;
        check("t6_ready_after_release", st_ready, 0);
        @(negedge clk_bus);
        check("t6_ready_rises", st_ready, 1);
        repeat (5) @(negedge clk_bus);
        check("t6_fifo_empty", nemit - b, 0);
        for (int i = 0; i < 5; i++) beat(8'(8'h10 + i), i == 0, i == 4);
        drain();
        check("t6_hdr", got[b][BUS-1:SPB], 22'h10000);
        check("t6_payload", got[b][39:0], 40'h1413121110);

        check("perr_total", perr_seen, exp_perr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
